// File: rtl/bcd_to_binary_sequencer_pkg.sv
// Shared definitions for the BCD-to-binary sequencer: FSM states and digit constants.
package bcd_to_binary_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
    localparam int unsigned MUL_TEN       = 10;

endpackage

// File: rtl/bcd_to_binary_sequencer_digit_mac.sv
// Combinational digit step: acc*10 + digit, with a flag for non-decimal nibbles.
module bcd_digit_mac
    import bcd_to_binary_sequencer_pkg::*;
#(
    parameter int unsigned ACC_W = 20
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [ACC_W-1:0] acc_next,
    output logic             bad
);

    // Accumulate one decimal digit and flag anything above 9
    always_comb begin
        acc_next = acc * ACC_W'(MUL_TEN) + ACC_W'(digit);
        bad      = (digit > BCD_MAX_DIGIT);
    end

endmodule

// File: rtl/bcd_to_binary_sequencer.sv
// Sequential packed-BCD to binary converter, one digit per cycle, MSD first,
// with valid/ready handshakes on both sides.
module bcd_to_binary_sequencer
    import bcd_to_binary_sequencer_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bin_out,
    output logic                  err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned IN_W  = 4 * DIGITS;
    localparam int unsigned ACC_W = IN_W + 4;
    localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t            state;
    state_t            state_next;
    logic [IN_W-1:0]   sreg;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  mac_acc;
    logic [CNT_W-1:0]  cnt;
    logic              err_r;
    logic              mac_bad;
    logic [3:0]        digit;
    logic              last_digit;

    assign digit      = sreg[IN_W-1 -: 4];
    assign last_digit = (cnt == CNT_W'(DIGITS - 1));

    bcd_digit_mac #(
        .ACC_W (ACC_W)
    ) u_mac (
        .acc      (acc),
        .digit    (digit),
        .acc_next (mac_acc),
        .bad      (mac_bad)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/result outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        bin_out    = '0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                bin_out   = err_r ? '0 : acc[IN_W-1:0];
                err       = err_r;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture and per-digit accumulation datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg  <= '0;
            acc   <= '0;
            cnt   <= '0;
            err_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg  <= bcd_in;
                        acc   <= '0;
                        cnt   <= '0;
                        err_r <= 1'b0;
                    end
                end
                CONV: begin
                    acc   <= mac_acc;
                    err_r <= err_r | mac_bad;
                    cnt   <= cnt + CNT_W'(1);
                    sreg  <= sreg << 4;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary_sequencer.sv
// Directed self-checking bench for bcd_to_binary_sequencer (DIGITS=4).
module tb_bcd_to_binary_sequencer;

    logic        clk;
    logic        rst_n;
    logic [15:0] bcd_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bin_out;
    logic        err;
    logic        out_valid;
    logic        out_ready;

    int unsigned checks;
    int unsigned errors;

    typedef struct {
        logic [15:0] bcd;
        logic [15:0] bin;
        logic        err;
    } vec_t;

    vec_t vecs[10];

    bcd_to_binary_sequencer #(
        .DIGITS (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bcd_in    (bcd_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_out   (bin_out),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One full transaction with out_ready=1: latency, result and handshake checks.
    task automatic convert(input logic [15:0] bcd, input logic [15:0] exp_bin, input logic exp_err);
        int lat;
        @(negedge clk);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        bcd_in    = bcd;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
        end else begin
            chk("latency", lat, 32'd5);
            chk("bin_out", {16'd0, bin_out}, {16'd0, exp_bin});
            chk("err", {31'd0, err}, {31'd0, exp_err});
            chk("in_ready_done", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
            chk("in_ready_back", {31'd0, in_ready}, 32'd1);
            chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        int lat;
        int seen;
        int idx;
        int ncyc;
        int res_cyc[3];
        logic [15:0] res_val[3];
        logic [15:0] b2b_in[3];
        logic [15:0] b2b_exp[3];

        checks = 0;
        errors = 0;

        vecs[0] = '{16'h1234, 16'h04D2, 1'b0};
        vecs[1] = '{16'h9999, 16'h270F, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b0};
        vecs[3] = '{16'h12A4, 16'h0000, 1'b1};
        vecs[4] = '{16'h0905, 16'h0389, 1'b0};
        vecs[5] = '{16'h5678, 16'h162E, 1'b0};
        vecs[6] = '{16'hF000, 16'h0000, 1'b1};
        vecs[7] = '{16'h0099, 16'h0063, 1'b0};
        vecs[8] = '{16'h999B, 16'h0000, 1'b1};
        vecs[9] = '{16'h1000, 16'h03E8, 1'b0};

        b2b_in[0]  = 16'h0001; b2b_exp[0] = 16'd1;
        b2b_in[1]  = 16'h0010; b2b_exp[1] = 16'd10;
        b2b_in[2]  = 16'h0100; b2b_exp[2] = 16'd100;

        rst_n     = 1'b0;
        bcd_in    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_bin_out", {16'd0, bin_out}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            convert(vecs[i].bcd, vecs[i].bin, vecs[i].err);
        end

        // Backpressure: hold the result for 7 cycles, ignore a new request meanwhile
        @(negedge clk);
        bcd_in    = 16'h0042;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_latency", lat, 32'd5);
        bcd_in   = 16'h1111;
        in_valid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_bin_out", {16'd0, bin_out}, 32'h2A);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_idle", {31'd0, in_ready}, 32'd1);
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("bp_nothing_queued", seen, 32'd0);

        // Reset two cycles into CONV aborts the conversion
        bcd_in   = 16'h5678;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_result", seen, 32'd0);
        convert(16'h0007, 16'h0007, 1'b0);

        // Back-to-back with in_valid held high
        idx   = 0;
        seen  = 0;
        ncyc  = 0;
        out_ready = 1'b1;
        while (ncyc < 40) begin
            @(negedge clk);
            ncyc++;
            if (out_valid && seen < 3) begin
                res_cyc[seen] = ncyc;
                res_val[seen] = bin_out;
                seen++;
            end
            if (in_ready) begin
                if (idx < 3) begin
                    bcd_in   = b2b_in[idx];
                    in_valid = 1'b1;
                    idx++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        chk("b2b_count", seen, 32'd3);
        if (seen == 3) begin
            for (int k = 0; k < 3; k++) begin
                chk("b2b_value", {16'd0, res_val[k]}, {16'd0, b2b_exp[k]});
            end
            chk("b2b_spacing01", res_cyc[1] - res_cyc[0], 32'd6);
            chk("b2b_spacing12", res_cyc[2] - res_cyc[1], 32'd6);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
